alu_mult_seq: RTL and testbench

//  Iterative shift-add multiplier controller that borrows the shared ALU adder for one add per multiplier bit.

---
 rtl/alu_mult_seq_pkg.sv | 21 ++
 rtl/alu_mult_seq.sv | 129 ++++++++++++
 tb/tb_alu_mult_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mult_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier and the ALU
// control decoder: ALU control codes and the multiplier controller states.
package alu_mult_seq_pkg;

    // ALU control codes, shared with alu_control
    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b010;

    // Multiplier controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ALU code driven by the multiplier: add only while it owns the ALU
    function automatic logic [2:0] mult_alu_code(input logic owned);
        return owned ? ALU_ADD : ALU_NOP;
    endfunction

endpackage

// File: rtl/alu_mult_seq.sv
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.
// One add per multiplier bit is borrowed from the shared ALU via alu_req/alu_gnt;
// while granted it overrides the decoded ALU control code with ALU_ADD.
// Optional build macro MULT_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero, with the accumulator realigned so the product is exact.
module alu_mult_seq
    import alu_mult_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 alu_req,
    input  logic                 alu_gnt,
    output logic [2:0]           alu_ctr,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_cout
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // Accumulator after one iteration, and the value captured on finishing
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   acc_fin;
    logic                 rem_zero;
`ifdef MULT_EARLY_TERM_EN
    logic [WIDTH-1:0]     rem_mask;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        // acc[0] selects add-and-shift (carry becomes the new top bit) or plain shift
        acc_step = acc_q[0] ? {alu_cout, alu_result, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

`ifdef MULT_EARLY_TERM_EN
        // After the shift, multiplier bits still unused sit in acc[WIDTH-2-cnt:0];
        // the bits above them are already low product bits, so they are masked off.
        rem_mask = {WIDTH{1'b1}} >> (cnt_q + CNT_W'(1));
        rem_zero = (acc_step[WIDTH-1:0] & rem_mask) == '0;
        // Skipped iterations would only shift right; apply them in one step.
        acc_fin  = acc_step >> (LAST_CNT - cnt_q);
`else
        rem_zero = 1'b0;
        acc_fin  = acc_step;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    acc_d   = {{WIDTH{1'b0}}, op_b};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Without a grant nothing moves; the same iteration retries next cycle
                if (alu_gnt) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT || rem_zero) begin
                        // Product is captured on entry so it is valid during the done cycle
                        acc_d     = acc_fin;
                        product_d = acc_fin;
                        state_d   = DONE;
                    end else begin
                        acc_d = acc_step;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the current state
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        alu_req = (state_q == RUN);
        alu_ctr = mult_alu_code(alu_req && alu_gnt);
        alu_a   = alu_req ? acc_q[2*WIDTH-1:WIDTH] : '0;
        alu_b   = alu_req ? mcand_q : '0;
        product = product_q;
    end

    // State and datapath registers; reset aborts any operation in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Scoreboard bench for alu_mult_seq: stimulus pushes expected product and
// latency; a monitor pops and compares on each done pulse. ALU is a plain adder.
module tb_alu_mult_seq;
    import alu_mult_seq_pkg::*;

    localparam int W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             start = 1'b0;
    logic [W-1:0]     op_a = '0;
    logic [W-1:0]     op_b = '0;
    logic             busy, done;
    logic [2*W-1:0]   product;
    logic             alu_req;
    logic             alu_gnt = 1'b1;
    logic [2:0]       alu_ctr;
    logic [W-1:0]     alu_a, alu_b, alu_result;
    logic             alu_cout;

    alu_mult_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_ctr    (alu_ctr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] prod;
        int             lat;
        int             t0;
        logic [W-1:0]   a;
    } exp_t;
    exp_t sbq[$];

    int n_chk = 0;
    int n_fail = 0;
    int start_cyc = -1000;
    int st_s = 0;
    int st_l = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Cycles from the start cycle to the done cycle: the multiplier needs n granted
    // RUN cycles; any RUN cycle inside the stall window is not granted.
    function automatic int exp_lat(input logic [W-1:0] b, input int s, input int l);
        int n, t, g;
        n = W;
`ifdef MULT_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
`endif
        t = 0;
        g = 0;
        while (g < n) begin
            t++;
            if (!(t >= s && t < s + l)) g++;
        end
        return t + 1;
    endfunction

    // Arbiter model: grant withheld in cycles [st_s, st_s+st_l) counted from the start cycle
    initial begin
        forever begin
            int r;
            @(negedge clk);
            r = cyc - start_cyc;
            alu_gnt = !(r >= st_s && r < st_s + st_l);
        end
    end

    // Monitor: ALU interface sanity every cycle, scoreboard pop on done
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            #1;
            if (alu_req) begin
                chk("alu_ctr_run", 64'(alu_ctr), 64'(alu_gnt ? ALU_ADD : ALU_NOP));
                if (sbq.size() > 0) chk("alu_b_mcand", 64'(alu_b), 64'(sbq[0].a));
            end else begin
                chk("alu_idle_ctr_a_b", 64'({alu_ctr, alu_a, alu_b}), 64'({ALU_NOP, {2*W{1'b0}}}));
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("done_with_empty_scoreboard", 64'(sbq.size()), 64'(1));
                end else begin
                    e = sbq.pop_front();
                    chk("product", 64'(product), 64'(e.prod));
                    chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                    chk("busy_in_done", 64'(busy), 64'(1));
                    @(negedge clk);
                    #1;
                    chk("done_one_cycle", 64'(done), 64'(0));
                    chk("product_hold", 64'(product), 64'(e.prod));
                end
            end
        end
    end

    // poke: 0 none, 1 start pulse mid-RUN, 2 start pulse in the DONE cycle
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int s, input int l, input int poke);
        exp_t e;
        logic [2*W-1:0] pa, pb;
        int guard;
        guard = 0;
        while (busy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        pa = {{W{1'b0}}, a};
        pb = {{W{1'b0}}, b};
        st_s = s;
        st_l = l;
        op_a = a;
        op_b = b;
        start = 1'b1;
        start_cyc = cyc;
        e.prod = pa * pb;
        e.lat = exp_lat(b, s, l);
        e.t0 = cyc;
        e.a = a;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op_a = W'($urandom);
        op_b = W'($urandom);
        if (poke == 1) begin
            repeat (3) @(negedge clk);
            op_a = W'(2);
            op_b = W'(2);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else if (poke == 2) begin
            guard = 0;
            while (!done && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            op_a = W'(2);
            op_b = W'(2);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        guard = 0;
        while (busy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL txn_timeout: busy still %0b after %0d cycles, required 0", busy, guard);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_product", 64'(product), 64'(0));
        chk("reset_alu_req", 64'(alu_req), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_txn(16'd3, 16'd5, 0, 0, 0);
        run_txn(16'hFFFF, 16'hFFFF, 0, 0, 0);
        run_txn(16'h1234, 16'h0000, 0, 0, 0);
        run_txn(16'd7, 16'd9, 5, 3, 0);
        run_txn(16'hABCD, 16'h9003, 0, 0, 1);
        run_txn(16'h00C3, 16'h0001, 0, 0, 2);
        run_txn(16'h0000, 16'hFFFF, 1, 2, 0);
        run_txn(16'hFFFF, 16'h8000, 15, 4, 0);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom) >> $urandom_range(0, 15);
            run_txn(ra, rb, int'($urandom_range(1, 20)), int'($urandom_range(0, 4)), 0);
        end

        // Reset mid-RUN: outputs return to reset values at once, no done afterwards
        run_txn(16'd3, 16'd5, 0, 0, 0);
        st_l = 0;
        op_a = 16'd11;
        op_b = 16'd13;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_alu_req", 64'(alu_req), 64'(0));
        chk("abort_alu_ctr", 64'(alu_ctr), 64'(ALU_NOP));
        chk("abort_alu_a", 64'(alu_a), 64'(0));
        chk("abort_alu_b", 64'(alu_b), 64'(0));
        chk("abort_product", 64'(product), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("idle_after_abort", 64'(busy), 64'(0));

        run_txn(16'h0100, 16'h0300, 2, 2, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
